input_fifo: RTL and testbench

INPUT_FIFO -- requirements
Module: input_fifo

---
 rtl/input_fifo_pkg.sv | 21 ++
 rtl/input_fifo_if.sv | 31 +++
 rtl/fifo_framer.sv | 71 +++++++
 rtl/input_fifo.sv | 85 ++++++++
 tb/tb_input_fifo.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/input_fifo_pkg.sv
// Shared definitions for the router input FIFO:
// flit codes, field positions and framer states.
package input_fifo_pkg;

    localparam int FLIT_ID_W = 3;
    localparam int DST_W     = 4;
    localparam int DST_LSB   = 0;
    localparam int ERR_W     = 8;

    localparam logic [FLIT_ID_W-1:0] FLIT_HEADER  = 3'b001;
    localparam logic [FLIT_ID_W-1:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [FLIT_ID_W-1:0] FLIT_TAIL    = 3'b100;

    localparam logic [ERR_W-1:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/input_fifo_if.sv
// Write/read bundle of the input FIFO.
// slave = the FIFO, master = upstream/routing side.
interface input_fifo_if
    import input_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] flit_in;
    logic                  valid_in;
    logic                  ready_out;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] flit_out;
    logic [FLIT_ID_W-1:0]  flit_id;
    logic [DST_W-1:0]      dst_addr;
    logic                  empty;
    logic                  full;
    logic                  frame_err;
    logic [ERR_W-1:0]      err_cnt;

    modport slave (
        input  flit_in, valid_in, read_en,
        output ready_out, flit_out, flit_id, dst_addr,
        output empty, full, frame_err, err_cnt
    );

    modport master (
        output flit_in, valid_in, read_en,
        input  ready_out, flit_out, flit_id, dst_addr,
        input  empty, full, frame_err, err_cnt
    );
endinterface

// File: rtl/fifo_framer.sv
// Write-side packet framing check: decides which
// accepted flits are stored and counts dropped ones.
module fifo_framer
    import input_fifo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 xfer,
    input  logic [FLIT_ID_W-1:0] id,
    output logic                 wr,
    output logic                 frame_err,
    output logic [ERR_W-1:0]     err_cnt
);
    frame_state_e     state_q, state_d;
    logic             frame_err_q, frame_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             drop;

    // Next state, store/drop decision and error tally.
    always_comb begin
        state_d     = state_q;
        wr          = 1'b0;
        drop        = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (xfer) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (id == FLIT_HEADER) begin
                        wr      = 1'b1;
                        state_d = ST_IN_PKT;
                    end else begin
                        drop = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    if (id == FLIT_PAYLOAD) begin
                        wr = 1'b1;
                    end else if (id == FLIT_TAIL) begin
                        wr      = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        frame_err_d = drop;
        if (drop && err_cnt_q != ERR_CNT_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/input_fifo.sv
// Router input FIFO: first-word fall-through flit
// storage guarded by a packet framing check.
module input_fifo
    import input_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
)(
    input  logic         clk,
    input  logic         rst,
    input_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  full, empty;
    logic                  xfer, pop, wr;
    logic [DATA_WIDTH-1:0] head;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign xfer  = bus.valid_in && !full;
    assign pop   = bus.read_en && !empty;

    fifo_framer u_framer (
        .clk       (clk),
        .rst       (rst),
        .xfer      (xfer),
        .id        (bus.flit_in[DATA_WIDTH-1 -: FLIT_ID_W]),
        .wr        (wr),
        .frame_err (bus.frame_err),
        .err_cnt   (bus.err_cnt)
    );

    // Pointer and occupancy update for write/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Flit storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= bus.flit_in;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.flit_out  = head;
    assign bus.flit_id   = head[DATA_WIDTH-1 -: FLIT_ID_W];
    assign bus.dst_addr  = head[DST_LSB +: DST_W];
    assign bus.ready_out = !full;
    assign bus.empty     = empty;
    assign bus.full      = full;

endmodule

// File: tb/tb_input_fifo.sv
// Bench for input_fifo: vector table plus
// scoreboard-checked corner sequences.
module tb_input_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] P = 3'b010;
    localparam logic [2:0] T = 3'b100;

    logic clk;
    logic rst;

    input_fifo_if #(.DATA_WIDTH(DW)) bus ();

    input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb [$];
    int m_cnt;
    bit m_in_pkt;
    int m_err;
    bit m_ferr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.valid_in = 1'b0;
        bus.read_en  = 1'b0;
        bus.flit_in  = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        m_cnt = 0;
        m_in_pkt = 1'b0;
        m_err = 0;
        m_ferr = 1'b0;
        #1;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ready", bus.ready_out, 1);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_errcnt", bus.err_cnt, 0);
    endtask

    // One cycle: drive at negedge, check head/ready
    // before the edge, check flags after it.
    task automatic step(input logic v, input logic [2:0] id,
                        input logic [3:0] dst, input logic rd,
                        output bit took);
        logic [DW-1:0] f;
        logic [DW-1:0] e;
        bit pop;
        bit acc;
        f = $urandom;
        f[DW-1 -: 3] = id;
        f[3:0] = dst;
        bus.flit_in  = f;
        bus.valid_in = v;
        bus.read_en  = rd;
        #1;
        chk("ready_out", bus.ready_out, m_cnt != DEPTH);
        pop = rd && (m_cnt != 0);
        if (pop) begin
            e = sb.pop_front();
            chk("flit_out", bus.flit_out, e);
            chk("flit_id", bus.flit_id, e[DW-1 -: 3]);
            chk("dst_addr", bus.dst_addr, e[3:0]);
        end
        took = v && (m_cnt != DEPTH);
        acc = 1'b0;
        if (took) begin
            if (!m_in_pkt) begin
                acc = (id == H);
                if (acc) m_in_pkt = 1'b1;
            end else begin
                acc = (id == P) || (id == T);
                if (id == T) m_in_pkt = 1'b0;
            end
        end
        m_ferr = took && !acc;
        if (m_ferr && m_err < 255) m_err++;
        if (acc) sb.push_back(f);
        m_cnt = m_cnt + int'(acc) - int'(pop);
        @(posedge clk);
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.read_en  = 1'b0;
        #1;
        chk("empty", bus.empty, m_cnt == 0);
        chk("full", bus.full, m_cnt == DEPTH);
        chk("frame_err", bus.frame_err, m_ferr);
        chk("err_cnt", bus.err_cnt, m_err);
    endtask

    typedef struct {
        bit        v;
        bit [2:0]  id;
        bit [3:0]  dst;
        bit        rd;
        bit        e_empty;
        bit        e_full;
        bit        e_ferr;
        bit [7:0]  e_err;
    } vec_t;

    vec_t vec [23];

    initial begin
        bit tk;
        int tries;
        vec[0]  = '{1, H, 4'h9, 0, 0, 0, 0, 0};
        vec[1]  = '{1, P, 4'h1, 0, 0, 0, 0, 0};
        vec[2]  = '{1, T, 4'h2, 0, 0, 0, 0, 0};
        vec[3]  = '{1, H, 4'h5, 0, 0, 1, 0, 0};
        vec[4]  = '{1, P, 4'h6, 0, 0, 1, 0, 0};
        vec[5]  = '{0, P, 4'h0, 1, 0, 0, 0, 0};
        vec[6]  = '{1, P, 4'h7, 0, 0, 1, 0, 0};
        vec[7]  = '{1, P, 4'h8, 1, 0, 0, 0, 0};
        vec[8]  = '{1, P, 4'ha, 1, 0, 0, 0, 0};
        vec[9]  = '{1, T, 4'hb, 0, 0, 1, 0, 0};
        vec[10] = '{0, H, 4'h0, 1, 0, 0, 0, 0};
        vec[11] = '{0, H, 4'h0, 1, 0, 0, 0, 0};
        vec[12] = '{0, H, 4'h0, 1, 0, 0, 0, 0};
        vec[13] = '{0, H, 4'h0, 1, 1, 0, 0, 0};
        vec[14] = '{0, H, 4'h0, 1, 1, 0, 0, 0};
        vec[15] = '{1, P, 4'h1, 0, 1, 0, 1, 1};
        vec[16] = '{0, H, 4'h0, 0, 1, 0, 0, 1};
        vec[17] = '{1, H, 4'h3, 0, 0, 0, 0, 1};
        vec[18] = '{1, H, 4'h4, 0, 0, 0, 1, 2};
        vec[19] = '{1, T, 4'hc, 0, 0, 0, 0, 2};
        vec[20] = '{1, 3'b111, 4'hd, 0, 0, 0, 1, 3};
        vec[21] = '{0, H, 4'h0, 1, 0, 0, 0, 3};
        vec[22] = '{0, H, 4'h0, 1, 1, 0, 0, 3};

        do_reset();
        for (int i = 0; i < 23; i++) begin
            step(vec[i].v, vec[i].id, vec[i].dst, vec[i].rd, tk);
            chk($sformatf("tbl%0d_empty", i), bus.empty, vec[i].e_empty);
            chk($sformatf("tbl%0d_full", i), bus.full, vec[i].e_full);
            chk($sformatf("tbl%0d_ferr", i), bus.frame_err, vec[i].e_ferr);
            chk($sformatf("tbl%0d_err", i), bus.err_cnt, vec[i].e_err);
            if (i == 2) begin
                chk("three_head_id", bus.flit_id, 3'b001);
                chk("three_head_dst", bus.dst_addr, 4'h9);
            end
            if (i == 3) begin
                chk("full_ready", bus.ready_out, 0);
            end
        end

        // Reset mid-packet discards storage and framing.
        do_reset();
        step(1, P, 4'h0, 0, tk);
        step(1, H, 4'h2, 0, tk);
        step(1, P, 4'h3, 0, tk);
        do_reset();
        step(1, T, 4'h4, 0, tk);
        chk("rst_tail_ferr", bus.frame_err, 1);
        chk("rst_tail_err", bus.err_cnt, 1);
        chk("rst_tail_empty", bus.empty, 1);

        // Error counter saturation.
        for (int i = 0; i < 258; i++) begin
            step(1, 3'b011, 4'h0, 0, tk);
        end
        chk("sat_err", bus.err_cnt, 8'd255);
        step(0, H, 4'h0, 0, tk);
        chk("sat_hold", bus.err_cnt, 8'd255);

        // Ten packets with random pops; pointers wrap.
        do_reset();
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < (p % 3) + 2; k++) begin
                logic [2:0] id;
                id = (k == 0) ? H : ((k == (p % 3) + 1) ? T : P);
                tries = 0;
                tk = 1'b0;
                while (!tk && tries < 20) begin
                    step(1, id, 4'(p), 1'($urandom_range(0, 1)), tk);
                    tries++;
                end
                if (!tk) chk("push_timeout", 0, 1);
            end
        end
        tries = 0;
        while (m_cnt > 0 && tries < 2 * DEPTH) begin
            step(0, H, 4'h0, 1, tk);
            tries++;
        end
        chk("drain_empty", bus.empty, 1);
        chk("pkts_err", bus.err_cnt, 0);
        chk("sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
